// File: rtl/prim_mem_bridge_pkg.sv
// Shared constants and types for the Prim CPU to byte-wide SRAM bridge.
package prim_mem_bridge_pkg;

  localparam logic [1:0] BS_NONE = 2'b00;
  localparam logic [1:0] BS_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_DONE
  } state_e;

  // Only 11 is a word; 10 falls back to a single byte like 01.
  function automatic logic is_word(input logic [1:0] bs);
    return bs == BS_WORD;
  endfunction

endpackage

// File: rtl/prim_mem_bridge_if.sv
// Prim CPU request/acknowledge bus; master = CPU side, slave = bridge side.
interface prim_mem_bridge_if;
  logic [15:0] addr;
  logic [15:0] wdat;
  logic [15:0] rdat;
  logic [1:0]  bs;
  logic        we;
  logic        ack;

  modport master (output addr, wdat, bs, we, input rdat, ack);
  modport slave  (input addr, wdat, bs, we, output rdat, ack);
endinterface

// File: rtl/prim_mem_bridge_wait_counter.sv
// Slot-length down-counter: reloads WAIT_STATES on load, flags last at zero.
module prim_mem_bridge_wait_counter #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic load,
  output logic last
);

  localparam int unsigned CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset)   cnt <= '0;
    else if (load) cnt <= CW'(WAIT_STATES);
    else           cnt <= cnt - 1'b1;
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/prim_mem_bridge.sv
// Serves 16-bit Prim CPU requests from an 8-bit SRAM as one or two byte slots.
// state | meaning: IDLE wait for bs!=00 | LO low byte slot | HI high byte slot | DONE ack pulse
module prim_mem_bridge
  import prim_mem_bridge_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  prim_mem_bridge_if.slave  bus,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_wdat,
  input  logic [7:0]        sram_rdat,
  output logic              sram_cs,
  output logic              sram_we
);

  state_e      state, nxt;
  logic [15:0] addr_q, dat_q, rdat_q, slot_addr;
  logic [7:0]  lo_q;
  logic        we_q, word_q;
  logic        in_slot, slot_last, cnt_load;

  assign in_slot  = (state == ST_LO) || (state == ST_HI);
  assign cnt_load = !in_slot || slot_last;

  prim_mem_bridge_wait_counter #(.WAIT_STATES(WAIT_STATES)) u_wait (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .load    (cnt_load),
    .last    (slot_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      dat_q  <= '0;
      we_q   <= 1'b0;
      word_q <= 1'b0;
      lo_q   <= '0;
      rdat_q <= '0;
    end else begin
      state <= nxt;
      if (state == ST_IDLE && bus.bs != BS_NONE) begin
        addr_q <= bus.addr;
        dat_q  <= bus.wdat;
        we_q   <= bus.we;
        word_q <= is_word(bus.bs);
      end
      if (state == ST_LO && slot_last) begin
        lo_q <= sram_rdat;
        if (!word_q && !we_q) rdat_q <= {8'h00, sram_rdat};
      end
      if (state == ST_HI && slot_last && !we_q) rdat_q <= {sram_rdat, lo_q};
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (bus.bs != BS_NONE) nxt = ST_LO;
      ST_LO:   if (slot_last) nxt = word_q ? ST_HI : ST_DONE;
      ST_HI:   if (slot_last) nxt = ST_DONE;
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // High byte address wraps in the 16-bit CPU space before resizing to the SRAM.
  assign slot_addr = (state == ST_HI) ? addr_q + 16'd1 : addr_q;
  assign sram_addr = ADDR_W'(slot_addr);
  assign sram_wdat = (state == ST_HI) ? dat_q[15:8] : dat_q[7:0];
  assign sram_cs   = in_slot;
  assign sram_we   = in_slot && slot_last && we_q;
  assign bus.rdat  = rdat_q;
  assign bus.ack   = (state == ST_DONE);

endmodule

// File: tb/tb_prim_mem_bridge.sv
// Bench for prim_mem_bridge: directed cases plus randomized accesses vs. a byte-array model.
module tb_prim_mem_bridge;
  import prim_mem_bridge_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prim_mem_bridge_if bif0 ();
  prim_mem_bridge_if bif2 ();

  logic [15:0] sa0, sa2;
  logic [7:0]  swd0, swd2, srd0, srd2;
  logic        cs0, cs2, we0, we2;

  prim_mem_bridge #(.WAIT_STATES(0), .ADDR_W(16)) dut0 (
    .i_clk(clk), .i_reset(rst), .bus(bif0),
    .sram_addr(sa0), .sram_wdat(swd0), .sram_rdat(srd0), .sram_cs(cs0), .sram_we(we0)
  );

  prim_mem_bridge #(.WAIT_STATES(2), .ADDR_W(16)) dut2 (
    .i_clk(clk), .i_reset(rst), .bus(bif2),
    .sram_addr(sa2), .sram_wdat(swd2), .sram_rdat(srd2), .sram_cs(cs2), .sram_we(we2)
  );

  // SRAM models (combinational read, write on the clock edge) with a bench preload port.
  logic [7:0]  mem0 [65536] = '{default: 8'h00};
  logic [7:0]  mem2 [65536] = '{default: 8'h00};
  logic [7:0]  ref0 [65536] = '{default: 8'h00};
  logic [7:0]  ref2 [65536] = '{default: 8'h00};
  logic        pre_en = 1'b0, pre_sel = 1'b0;
  logic [15:0] pre_a = '0;
  logic [7:0]  pre_d = '0;

  assign srd0 = mem0[sa0];
  assign srd2 = mem2[sa2];

  always @(posedge clk) begin
    if (pre_en && !pre_sel) mem0[pre_a] <= pre_d;
    else if (cs0 && we0)    mem0[sa0] <= swd0;
  end
  always @(posedge clk) begin
    if (pre_en && pre_sel) mem2[pre_a] <= pre_d;
    else if (cs2 && we2)   mem2[sa2] <= swd2;
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_dat [2] = '{16'h0000, 16'h0000};

  task automatic poke(input bit sel, input logic [15:0] a, input logic [7:0] d);
    pre_en = 1'b1; pre_sel = sel; pre_a = a; pre_d = d;
    if (sel) ref2[a] = d; else ref0[a] = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic set_bus(input bit sel, input logic [15:0] a, input logic [15:0] d,
                         input logic [1:0] bs, input logic we);
    if (sel) begin bif2.addr = a; bif2.wdat = d; bif2.bs = bs; bif2.we = we; end
    else     begin bif0.addr = a; bif0.wdat = d; bif0.bs = bs; bif0.we = we; end
  endtask

  // Presents one request in the current (IDLE) cycle t and reports the ack cycle
  // relative to t (-1 on timeout) plus chip-select / write-strobe activity.
  task automatic run_access(input bit sel, input logic [15:0] a, input logic [15:0] d,
                            input logic [1:0] bs, input logic we,
                            output int lat, output int ncs, output int nwe, output int we_cyc);
    set_bus(sel, a, d, bs, we);
    lat = -1; ncs = 0; nwe = 0; we_cyc = -1;
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (sel ? cs2 : cs0) ncs++;
      if (sel ? we2 : we0) begin nwe++; we_cyc = c; end
      if (sel ? bif2.ack : bif0.ack) begin lat = c; break; end
    end
    set_bus(sel, 16'h0000, 16'h0000, BS_NONE, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_bus(0, 16'h1234, 16'h5678, BS_NONE, 1'b0);
    set_bus(1, 16'h1234, 16'h5678, BS_NONE, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bif0.ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b expected 0", bif0.ack); end
    n_cmp++; if (bif0.rdat !== 16'h0000) begin n_err++; $display("FAIL reset_rdat: got %h expected 0000", bif0.rdat); end
    n_cmp++; if ({cs0, we0, cs2, we2} !== 4'b0000) begin n_err++; $display("FAIL reset_cs_we: got %b expected 0000", {cs0, we0, cs2, we2}); end
    n_cmp++; if ({sa0, swd0} !== 24'h000000) begin n_err++; $display("FAIL reset_sram_bus: got %h expected 000000", {sa0, swd0}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_idle();
    int busy = 0;
    set_bus(0, 16'h0040, 16'hFFFF, BS_NONE, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (cs0 || we0 || bif0.ack) busy++;
    end
    n_cmp++; if (busy !== 0) begin n_err++; $display("FAIL idle_no_activity: got %0d active cycles expected 0", busy); end
  endtask

  task automatic test_byte_read();
    int lat, ncs, nwe, wc;
    poke(0, 16'h0010, 8'hA5);
    run_access(0, 16'h0010, 16'h5A5A, 2'b01, 1'b0, lat, ncs, nwe, wc);
    exp_dat[0] = 16'h00A5;
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL byte_read_latency: got %0d expected 2", lat); end
    n_cmp++; if (bif0.rdat !== 16'h00A5) begin n_err++; $display("FAIL byte_read_data: got %h expected 00a5", bif0.rdat); end
  endtask

  task automatic test_word_read();
    int lat, ncs, nwe, wc;
    poke(0, 16'h0011, 8'h34);
    poke(0, 16'h0012, 8'h12);
    run_access(0, 16'h0011, 16'h0000, 2'b11, 1'b0, lat, ncs, nwe, wc);
    exp_dat[0] = 16'h1234;
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL word_read_latency: got %0d expected 3", lat); end
    n_cmp++; if (bif0.rdat !== 16'h1234) begin n_err++; $display("FAIL word_read_data: got %h expected 1234", bif0.rdat); end
  endtask

  task automatic test_word_write_wrap();
    int lat, ncs, nwe, wc;
    run_access(0, 16'hFFFF, 16'hBEEF, 2'b11, 1'b1, lat, ncs, nwe, wc);
    ref0[16'hFFFF] = 8'hEF;
    ref0[16'h0000] = 8'hBE;
    n_cmp++; if (mem0[16'hFFFF] !== 8'hEF) begin n_err++; $display("FAIL wrap_low_byte: got %h expected ef", mem0[16'hFFFF]); end
    n_cmp++; if (mem0[16'h0000] !== 8'hBE) begin n_err++; $display("FAIL wrap_high_byte: got %h expected be", mem0[16'h0000]); end
    n_cmp++; if (nwe !== 2) begin n_err++; $display("FAIL wrap_we_pulses: got %0d expected 2", nwe); end
    n_cmp++; if (bif0.rdat !== exp_dat[0]) begin n_err++; $display("FAIL wrap_rdat_held: got %h expected %h", bif0.rdat, exp_dat[0]); end
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL wrap_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_wait_states();
    int lat, ncs, nwe, wc;
    run_access(1, 16'h0100, 16'h0042, 2'b01, 1'b1, lat, ncs, nwe, wc);
    ref2[16'h0100] = 8'h42;
    n_cmp++; if (ncs !== 3) begin n_err++; $display("FAIL ws2_cs_cycles: got %0d expected 3", ncs); end
    n_cmp++; if (nwe !== 1 || wc !== 3) begin n_err++; $display("FAIL ws2_we_pulse: got %0d pulses last at cycle %0d expected 1 at 3", nwe, wc); end
    n_cmp++; if (mem2[16'h0100] !== 8'h42) begin n_err++; $display("FAIL ws2_mem: got %h expected 42", mem2[16'h0100]); end
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL ws2_latency: got %0d expected 4", lat); end
  endtask

  task automatic test_reset_mid();
    int lat, ncs, nwe, wc, busy;
    set_bus(0, 16'h0011, 16'h0000, 2'b11, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (!(cs0 && sa0 == 16'h0012)) begin n_err++; $display("FAIL midreset_in_hi: got cs=%b addr=%h expected cs=1 addr=0012", cs0, sa0); end
    rst = 1'b1;
    set_bus(0, 16'h0000, 16'h0000, BS_NONE, 1'b0);
    @(posedge clk); #1;
    exp_dat[0] = 16'h0000;
    exp_dat[1] = 16'h0000;
    n_cmp++; if ({bif0.ack, cs0, we0} !== 3'b000) begin n_err++; $display("FAIL midreset_outputs: got ack/cs/we=%b expected 000", {bif0.ack, cs0, we0}); end
    n_cmp++; if (bif0.rdat !== 16'h0000) begin n_err++; $display("FAIL midreset_rdat: got %h expected 0000", bif0.rdat); end
    rst = 1'b0;
    busy = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bif0.ack || cs0) busy++;
    end
    n_cmp++; if (busy !== 0) begin n_err++; $display("FAIL midreset_no_ack: got %0d active cycles expected 0", busy); end
    run_access(0, 16'h0010, 16'h0000, 2'b01, 1'b0, lat, ncs, nwe, wc);
    exp_dat[0] = {8'h00, ref0[16'h0010]};
    n_cmp++; if (lat !== 2 || bif0.rdat !== exp_dat[0]) begin n_err++; $display("FAIL midreset_recover: got lat=%0d rdat=%h expected lat=2 rdat=%h", lat, bif0.rdat, exp_dat[0]); end
  endtask

  task automatic test_held_request();
    int nack = 0, ncs = 0, overlap = 0;
    int ack_c [2] = '{-1, -1};
    poke(0, 16'h0020, 8'($urandom));
    set_bus(0, 16'h0020, 16'h0000, 2'b01, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (cs0) ncs++;
      if (bif0.ack) begin
        if (cs0) overlap++;
        if (nack < 2) ack_c[nack] = c;
        nack++;
        if (nack == 2) set_bus(0, 16'h0000, 16'h0000, BS_NONE, 1'b0);
      end
    end
    exp_dat[0] = {8'h00, ref0[16'h0020]};
    n_cmp++; if (nack !== 2) begin n_err++; $display("FAIL held_ack_count: got %0d expected 2", nack); end
    n_cmp++; if (ack_c[1] - ack_c[0] !== 3) begin n_err++; $display("FAIL held_ack_spacing: got %0d expected 3", ack_c[1] - ack_c[0]); end
    n_cmp++; if (ncs !== 2 || overlap !== 0) begin n_err++; $display("FAIL held_cs_activity: got %0d cs cycles %0d in DONE expected 2 and 0", ncs, overlap); end
    n_cmp++; if (bif0.rdat !== exp_dat[0]) begin n_err++; $display("FAIL held_rdat: got %h expected %h", bif0.rdat, exp_dat[0]); end
  endtask

  task automatic test_random();
    int lat, ncs, nwe, wc, w, n;
    bit sel;
    logic [15:0] a, a1, d, got;
    logic [1:0]  bs;
    logic        we;
    logic [7:0]  m_lo, m_hi, r_lo, r_hi;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 32; i++) poke(s[0], 16'h0300 + 16'(i), 8'($urandom));
      poke(s[0], 16'hFFFE, 8'($urandom));
      poke(s[0], 16'hFFFF, 8'($urandom));
      poke(s[0], 16'h0000, 8'($urandom));
    end
    for (int i = 0; i < 40; i++) begin
      sel = 1'($urandom);
      case ($urandom % 4)
        0:       a = 16'hFFFF;
        1:       a = 16'hFFFE;
        default: a = 16'h0300 + 16'($urandom % 30);
      endcase
      a1 = a + 16'd1;
      d  = 16'($urandom);
      bs = 2'($urandom_range(1, 3));
      we = 1'($urandom);
      w  = sel ? 2 : 0;
      n  = (bs == 2'b11) ? 2 : 1;
      if (we) begin
        if (sel) ref2[a] = d[7:0]; else ref0[a] = d[7:0];
        if (n == 2) begin
          if (sel) ref2[a1] = d[15:8]; else ref0[a1] = d[15:8];
        end
      end else begin
        r_lo = sel ? ref2[a] : ref0[a];
        r_hi = sel ? ref2[a1] : ref0[a1];
        exp_dat[sel] = (n == 2) ? {r_hi, r_lo} : {8'h00, r_lo};
      end
      run_access(sel, a, d, bs, we, lat, ncs, nwe, wc);
      got = sel ? bif2.rdat : bif0.rdat;
      n_cmp++; if (lat !== 1 + n * (w + 1)) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, 1 + n * (w + 1)); end
      n_cmp++; if (ncs !== n * (w + 1) || nwe !== (we ? n : 0)) begin n_err++; $display("FAIL rand_strobes[%0d]: got cs=%0d we=%0d expected cs=%0d we=%0d", i, ncs, nwe, n * (w + 1), we ? n : 0); end
      n_cmp++; if (got !== exp_dat[sel]) begin n_err++; $display("FAIL rand_rdat[%0d]: got %h expected %h", i, got, exp_dat[sel]); end
      m_lo = sel ? mem2[a] : mem0[a];
      m_hi = sel ? mem2[a1] : mem0[a1];
      r_lo = sel ? ref2[a] : ref0[a];
      r_hi = sel ? ref2[a1] : ref0[a1];
      n_cmp++; if ({m_hi, m_lo} !== {r_hi, r_lo}) begin n_err++; $display("FAIL rand_mem[%0d]: got %h expected %h at %h", i, {m_hi, m_lo}, {r_hi, r_lo}, a); end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_byte_read();
    test_word_read();
    test_word_write_wrap();
    test_wait_states();
    test_reset_mid();
    test_held_request();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
